// File: rtl/hazard_ctrl_if.sv
// Control bundle between the pipeline datapath and the hazard/flow controller.
// The datapath drives hazard sources through master; the controller drives stage controls through slave.
interface hazard_ctrl_if #(
  parameter int unsigned CNT_W = 32
);
  logic [4:0]       id_rs;
  logic [4:0]       id_rt;
  logic             id_uses_rs;
  logic             id_uses_rt;
  logic             id_jump;
  logic             id_halt;
  logic             ex_dmemread;
  logic [4:0]       ex_regwtaddr;
  logic             ex_branch_taken;
  logic             dmem_wait;
  logic             pc_en;
  logic             ifid_en;
  logic             ifid_flush;
  logic             idex_en;
  logic             idex_flush;
  logic             exmem_en;
  logic             halted;
  logic [CNT_W-1:0] stall_cnt;
  logic [CNT_W-1:0] flush_cnt;

  modport master (
    output id_rs, id_rt, id_uses_rs, id_uses_rt, id_jump, id_halt,
           ex_dmemread, ex_regwtaddr, ex_branch_taken, dmem_wait,
    input  pc_en, ifid_en, ifid_flush, idex_en, idex_flush, exmem_en,
           halted, stall_cnt, flush_cnt
  );

  modport slave (
    input  id_rs, id_rt, id_uses_rs, id_uses_rt, id_jump, id_halt,
           ex_dmemread, ex_regwtaddr, ex_branch_taken, dmem_wait,
    output pc_en, ifid_en, ifid_flush, idex_en, idex_flush, exmem_en,
           halted, stall_cnt, flush_cnt
  );
endinterface

// File: rtl/hazard_ctrl.sv
// Hazard and flow controller for the 5-stage pipeline: Mealy stage enables/flushes,
// post-reset flush sequencing, halt drain and saturating stall/flush statistics.
module hazard_ctrl #(
  parameter int unsigned STARTUP_CYCLES = 2,
  parameter int unsigned CNT_W          = 32
) (
  input logic         clk,
  input logic         rst,
  hazard_ctrl_if.slave bus
);
  localparam int unsigned SU_W = (STARTUP_CYCLES > 1) ? $clog2(STARTUP_CYCLES) : 1;

  typedef enum logic [1:0] {INIT, RUN, HALT} state_t;

  state_t           state, next_state;
  logic [SU_W-1:0]  su_cnt, su_next;
  logic [CNT_W-1:0] stall_cnt, flush_cnt;
  logic             stall_inc, flush_inc;
  logic             load_use;
  logic             pc_en, ifid_en, ifid_flush, idex_en, idex_flush, exmem_en;

  // Load in EX writes a register the ID instruction reads; r0 never creates a dependency.
  assign load_use = bus.ex_dmemread && (bus.ex_regwtaddr != 5'd0) &&
                    ((bus.id_uses_rs && (bus.id_rs == bus.ex_regwtaddr)) ||
                     (bus.id_uses_rt && (bus.id_rt == bus.ex_regwtaddr)));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= INIT;
      su_cnt    <= SU_W'(STARTUP_CYCLES - 1);
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      state  <= next_state;
      su_cnt <= su_next;
      if (stall_inc && (stall_cnt != '1)) stall_cnt <= stall_cnt + CNT_W'(1);
      if (flush_inc && (flush_cnt != '1)) flush_cnt <= flush_cnt + CNT_W'(1);
    end
  end

  always_comb begin
    next_state = state;
    su_next    = su_cnt;
    pc_en      = 1'b0;
    ifid_en    = 1'b0;
    ifid_flush = 1'b0;
    idex_en    = 1'b0;
    idex_flush = 1'b0;
    exmem_en   = 1'b1;
    stall_inc  = 1'b0;
    flush_inc  = 1'b0;
    case (state)
      INIT: begin
        ifid_flush = 1'b1;
        idex_flush = 1'b1;
        if (su_cnt == '0) next_state = RUN;
        else              su_next    = su_cnt - SU_W'(1);
      end
      RUN: begin
        if (bus.dmem_wait) begin
          exmem_en = 1'b0;
        end else if (bus.ex_branch_taken) begin
          pc_en      = 1'b1;
          ifid_en    = 1'b1;
          idex_en    = 1'b1;
          ifid_flush = 1'b1;
          idex_flush = 1'b1;
          flush_inc  = 1'b1;
        end else if (load_use) begin
          // Hold PC and IF/ID, inject a bubble into EX; a coincident jump/halt waits.
          idex_en    = 1'b1;
          idex_flush = 1'b1;
          stall_inc  = 1'b1;
        end else if (bus.id_halt) begin
          idex_en    = 1'b1;
          ifid_flush = 1'b1;
          next_state = HALT;
        end else if (bus.id_jump) begin
          pc_en      = 1'b1;
          ifid_en    = 1'b1;
          idex_en    = 1'b1;
          ifid_flush = 1'b1;
          flush_inc  = 1'b1;
        end else begin
          pc_en   = 1'b1;
          ifid_en = 1'b1;
          idex_en = 1'b1;
        end
      end
      HALT: begin
        ifid_flush = 1'b1;
        idex_flush = 1'b1;
        exmem_en   = !bus.dmem_wait;
      end
      default: next_state = INIT;
    endcase
  end

  assign bus.pc_en      = pc_en;
  assign bus.ifid_en    = ifid_en;
  assign bus.ifid_flush = ifid_flush;
  assign bus.idex_en    = idex_en;
  assign bus.idex_flush = idex_flush;
  assign bus.exmem_en   = exmem_en;
  assign bus.halted     = (state == HALT);
  assign bus.stall_cnt  = stall_cnt;
  assign bus.flush_cnt  = flush_cnt;
endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl: expectations are queued as each step is driven and
// popped for comparison at the following falling edge.
module tb_hazard_ctrl;
  // Control vector order: {pc_en, ifid_en, ifid_flush, idex_en, idex_flush, exmem_en, halted}
  localparam logic [6:0] C_INIT   = 7'b0010110;
  localparam logic [6:0] C_NORM   = 7'b1101010;
  localparam logic [6:0] C_FRZ    = 7'b0000000;
  localparam logic [6:0] C_BR     = 7'b1111110;
  localparam logic [6:0] C_LU     = 7'b0001110;
  localparam logic [6:0] C_HLT    = 7'b0011010;
  localparam logic [6:0] C_JMP    = 7'b1111010;
  localparam logic [6:0] C_HALTED = 7'b0010111;
  localparam logic [6:0] C_HALT_W = 7'b0010101;

  typedef struct {
    string       tag;
    bit          sel;
    logic [6:0]  ctl;
    logic [31:0] st;
    logic [31:0] fl;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic rst3 = 1'b1;
  int   checks = 0;
  int   failures = 0;
  exp_t sbq[$];

  hazard_ctrl_if #(.CNT_W(32)) hif ();
  hazard_ctrl_if #(.CNT_W(3))  hif3 ();

  hazard_ctrl #(.STARTUP_CYCLES(2), .CNT_W(32)) dut (.clk(clk), .rst(rst), .bus(hif.slave));
  hazard_ctrl #(.STARTUP_CYCLES(2), .CNT_W(3)) dut3 (.clk(clk), .rst(rst3), .bus(hif3.slave));

  always #5 clk = ~clk;

  task automatic drive(input logic dw, input logic br, input logic ld, input logic [4:0] wt,
                       input logic [4:0] rs, input logic urs, input logic [4:0] rt,
                       input logic urt, input logic jmp, input logic hlt);
    hif.dmem_wait       = dw;
    hif.ex_branch_taken = br;
    hif.ex_dmemread     = ld;
    hif.ex_regwtaddr    = wt;
    hif.id_rs           = rs;
    hif.id_uses_rs      = urs;
    hif.id_rt           = rt;
    hif.id_uses_rt      = urt;
    hif.id_jump         = jmp;
    hif.id_halt         = hlt;
  endtask

  task automatic push(input string tag, input bit sel, input logic [6:0] ctl,
                      input int unsigned st, input int unsigned fl);
    exp_t e;
    e.tag = tag;
    e.sel = sel;
    e.ctl = ctl;
    e.st  = 32'(st);
    e.fl  = 32'(fl);
    sbq.push_back(e);
  endtask

  task automatic check_all();
    exp_t        e;
    logic [6:0]  oc;
    logic [31:0] os, of;
    while (sbq.size() > 0) begin
      e = sbq.pop_front();
      if (e.sel) begin
        oc = {hif3.pc_en, hif3.ifid_en, hif3.ifid_flush, hif3.idex_en, hif3.idex_flush,
              hif3.exmem_en, hif3.halted};
        os = 32'(hif3.stall_cnt);
        of = 32'(hif3.flush_cnt);
      end else begin
        oc = {hif.pc_en, hif.ifid_en, hif.ifid_flush, hif.idex_en, hif.idex_flush,
              hif.exmem_en, hif.halted};
        os = hif.stall_cnt;
        of = hif.flush_cnt;
      end
      checks++;
      assert (oc === e.ctl) else begin
        failures++;
        $error("FAIL %s ctl observed=%b expected=%b", e.tag, oc, e.ctl);
      end
      checks++;
      assert (os === e.st) else begin
        failures++;
        $error("FAIL %s stall_cnt observed=%0d expected=%0d", e.tag, os, e.st);
      end
      checks++;
      assert (of === e.fl) else begin
        failures++;
        $error("FAIL %s flush_cnt observed=%0d expected=%0d", e.tag, of, e.fl);
      end
    end
  endtask

  task automatic tick();
    @(negedge clk);
    check_all();
    @(posedge clk);
    #1;
  endtask

  initial begin
    drive(0, 0, 0, 5'd0, 5'd0, 0, 5'd0, 0, 0, 0);
    hif3.dmem_wait = 0; hif3.ex_branch_taken = 0; hif3.ex_dmemread = 0;
    hif3.ex_regwtaddr = 5'd0; hif3.id_rs = 5'd0; hif3.id_rt = 5'd0;
    hif3.id_uses_rs = 0; hif3.id_uses_rt = 0; hif3.id_jump = 0; hif3.id_halt = 0;

    #2;
    push("rst_hold", 0, C_INIT, 0, 0);
    check_all();
    @(posedge clk); #1;
    rst = 0;

    // Startup: two flush cycles; hazards presented during INIT must be ignored.
    push("init0", 0, C_INIT, 0, 0); tick();
    drive(0, 1, 1, 5'd8, 5'd8, 1, 5'd0, 0, 1, 0);
    push("init1", 0, C_INIT, 0, 0); tick();
    drive(0, 0, 0, 5'd0, 5'd0, 0, 5'd0, 0, 0, 0);
    push("run", 0, C_NORM, 0, 0); tick();

    // Load-use detection and its qualifiers.
    drive(0, 0, 1, 5'd8, 5'd8, 1, 5'd0, 0, 0, 0);
    push("lu_rs", 0, C_LU, 0, 0); tick();
    drive(0, 0, 1, 5'd0, 5'd0, 1, 5'd0, 0, 0, 0);
    push("lu_r0", 0, C_NORM, 1, 0); tick();
    drive(0, 0, 1, 5'd8, 5'd8, 0, 5'd0, 0, 0, 0);
    push("lu_nouse", 0, C_NORM, 1, 0); tick();
    drive(0, 0, 1, 5'd9, 5'd3, 1, 5'd9, 1, 0, 0);
    push("lu_rt", 0, C_LU, 1, 0); tick();

    // Branch beats load-use and jump.
    drive(0, 1, 1, 5'd8, 5'd8, 1, 5'd0, 0, 1, 0);
    push("br_all", 0, C_BR, 2, 0); tick();
    drive(0, 0, 0, 5'd0, 5'd0, 0, 5'd0, 0, 0, 0);
    push("br_done", 0, C_NORM, 2, 1); tick();

    // Freeze over a pending load-use, then exactly one stall.
    drive(1, 0, 1, 5'd8, 5'd8, 1, 5'd0, 0, 0, 0);
    for (int i = 0; i < 3; i++) begin
      push("frz_lu", 0, C_FRZ, 2, 1); tick();
    end
    drive(0, 0, 1, 5'd8, 5'd8, 1, 5'd0, 0, 0, 0);
    push("lu_release", 0, C_LU, 2, 1); tick();
    drive(0, 0, 0, 5'd0, 5'd0, 0, 5'd0, 0, 0, 0);
    push("lu_once", 0, C_NORM, 3, 1); tick();

    // Freeze over a pending branch.
    drive(1, 1, 0, 5'd0, 5'd0, 0, 5'd0, 0, 0, 0);
    for (int i = 0; i < 2; i++) begin
      push("frz_br", 0, C_FRZ, 3, 1); tick();
    end
    drive(0, 1, 0, 5'd0, 5'd0, 0, 5'd0, 0, 0, 0);
    push("br_release", 0, C_BR, 3, 1); tick();
    drive(0, 0, 0, 5'd0, 5'd0, 0, 5'd0, 0, 0, 0);
    push("br_once", 0, C_NORM, 3, 2); tick();

    // Jump alone, then jump deferred behind a load-use.
    drive(0, 0, 0, 5'd0, 5'd0, 0, 5'd0, 0, 1, 0);
    push("jmp", 0, C_JMP, 3, 2); tick();
    drive(0, 0, 1, 5'd7, 5'd0, 0, 5'd7, 1, 1, 0);
    push("lu_jmp", 0, C_LU, 3, 3); tick();
    drive(0, 0, 0, 5'd7, 5'd0, 0, 5'd7, 1, 1, 0);
    push("jmp_defer", 0, C_JMP, 4, 3); tick();
    drive(0, 0, 0, 5'd0, 5'd0, 0, 5'd0, 0, 0, 0);
    push("post_jmp", 0, C_NORM, 4, 4); tick();

    // Halt and drain.
    drive(0, 0, 0, 5'd0, 5'd0, 0, 5'd0, 0, 0, 1);
    push("halt_dec", 0, C_HLT, 4, 4); tick();
    drive(0, 0, 0, 5'd0, 5'd0, 0, 5'd0, 0, 0, 0);
    push("halted", 0, C_HALTED, 4, 4); tick();
    drive(0, 1, 1, 5'd8, 5'd8, 1, 5'd0, 0, 1, 0);
    push("halt_ign", 0, C_HALTED, 4, 4); tick();
    drive(1, 0, 0, 5'd0, 5'd0, 0, 5'd0, 0, 0, 0);
    push("halt_wait", 0, C_HALT_W, 4, 4); tick();

    // Asynchronous reset out of HALT, seen before any clock edge.
    rst = 1;
    #1;
    push("rst_halt", 0, C_INIT, 0, 0);
    check_all();
    drive(0, 0, 0, 5'd0, 5'd0, 0, 5'd0, 0, 0, 0);
    @(posedge clk); #1;
    rst = 0;
    push("re_init0", 0, C_INIT, 0, 0); tick();
    push("re_init1", 0, C_INIT, 0, 0); tick();
    drive(1, 0, 0, 5'd0, 5'd0, 0, 5'd0, 0, 0, 0);
    push("frz2", 0, C_FRZ, 0, 0); tick();
    rst = 1;
    #1;
    push("rst_frz", 0, C_INIT, 0, 0);
    check_all();
    drive(0, 0, 0, 5'd0, 5'd0, 0, 5'd0, 0, 0, 0);

    // Narrow counters saturate instead of wrapping.
    @(posedge clk); #1;
    rst3 = 0;
    push("w3_init0", 1, C_INIT, 0, 0); tick();
    push("w3_init1", 1, C_INIT, 0, 0); tick();
    hif3.id_jump = 1;
    for (int i = 0; i < 10; i++) begin
      push($sformatf("w3_jmp%0d", i), 1, C_JMP, 0, (i < 7) ? i : 7); tick();
    end
    hif3.id_jump = 0;
    push("w3_sat", 1, C_NORM, 0, 7); tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
